nibble_serial_mult: RTL and testbench



---
 rtl/nibble_serial_mult_pkg.sv | 23 ++
 rtl/nibble_serial_mult_if.sv | 26 ++
 rtl/nibble_serial_mult_fastmult.sv | 20 ++
 rtl/nibble_serial_mult.sv | 133 +++++++++++++
 tb/tb_nibble_serial_mult.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_mult_pkg.sv
// Shared definitions for the nibble-serial multiplier: nibble width,
// sequencer state encoding and the nibble-count helpers.
package nibble_serial_mult_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of nibbles in an n-bit operand.
   function automatic int K(input int n);
      return n / NIBBLE_W;
   endfunction

   // Number of nibble-pair products needed for one n x n multiply.
   function automatic int RUN_CYCLES(input int n);
      return K(n) * K(n);
   endfunction

endpackage

// File: rtl/nibble_serial_mult_if.sv
// Operand/result handshake bundle for the nibble-serial multiplier.
// The slave side is the multiplier; the master side feeds operands and
// consumes results.
interface nibble_serial_mult_if #(parameter int N = 16);

   logic             io_in_valid;
   logic             io_in_ready;
   logic [N-1:0]     io_in_lhs;
   logic [N-1:0]     io_in_rhs;
   logic             io_flush;
   logic             io_out_valid;
   logic             io_out_ready;
   logic [2*N-1:0]   io_out_data;
   logic             io_busy;

   modport slave (
      input  io_in_valid, io_in_lhs, io_in_rhs, io_flush, io_out_ready,
      output io_in_ready, io_out_valid, io_out_data, io_busy
   );

   modport master (
      output io_in_valid, io_in_lhs, io_in_rhs, io_flush, io_out_ready,
      input  io_in_ready, io_out_valid, io_out_data, io_busy
   );

endinterface

// File: rtl/nibble_serial_mult_fastmult.sv
// FastMult: 4-bit x 4-bit unsigned multiplier implemented as a 256-entry
// lookup table addressed by the concatenated operands.
module FastMult
   import nibble_serial_mult_pkg::*;
(
   input  logic [NIBBLE_W-1:0]   io_lhs,
   input  logic [NIBBLE_W-1:0]   io_rhs,
   output logic [2*NIBBLE_W-1:0] io_prod
);

   logic [2*NIBBLE_W-1:0] w_lut [256];

   // Each table entry holds the product of the upper and lower address nibbles.
   for (genvar g = 0; g < 256; g++) begin : gLut
      assign w_lut[g] = 8'((g / 16) * (g % 16));
   end

   assign io_prod = w_lut[{io_lhs, io_rhs}];

endmodule

// File: rtl/nibble_serial_mult.sv
// nibble_serial_mult: iterative unsigned N x N multiplier. One operand pair
// is accepted, every lhs-nibble x rhs-nibble pair is pushed through a single
// FastMult (one pair per cycle), and the shifted partial products are summed
// into a 2N-bit accumulator that is presented on a valid/ready output.
module nibble_serial_mult
   import nibble_serial_mult_pkg::*;
#(
   parameter int N = 16
) (
   input logic                  clk,
   input logic                  reset,
   nibble_serial_mult_if.slave  io
);

   localparam int KN   = K(N);
   localparam int IDXW = (KN > 1) ? $clog2(KN) : 1;

   state_t                 r_state;
   state_t                 w_nextState;
   logic [N-1:0]           r_lhsQ;
   logic [N-1:0]           r_rhsQ;
   logic [2*N-1:0]         r_acc;
   logic [IDXW-1:0]        r_i;
   logic [IDXW-1:0]        r_j;

   logic [NIBBLE_W-1:0]    w_lhsNib;
   logic [NIBBLE_W-1:0]    w_rhsNib;
   logic [2*NIBBLE_W-1:0]  w_prod;
   logic [2*N-1:0]         w_ext;
   logic [2*N-1:0]         w_term;
   logic [31:0]            w_shamt;
   logic                   w_lastI;
   logic                   w_lastJ;

   assign w_lastI = (r_i == IDXW'(KN - 1));
   assign w_lastJ = (r_j == IDXW'(KN - 1));

   // Select the current lhs/rhs nibbles; the loop keeps every slice constant.
   always_comb begin
      w_lhsNib = '0;
      w_rhsNib = '0;
      for (int k = 0; k < KN; k++) begin
         if (r_i == IDXW'(k)) w_lhsNib = r_lhsQ[k*NIBBLE_W +: NIBBLE_W];
         if (r_j == IDXW'(k)) w_rhsNib = r_rhsQ[k*NIBBLE_W +: NIBBLE_W];
      end
   end

   FastMult uFastMult (
      .io_lhs  (w_lhsNib),
      .io_rhs  (w_rhsNib),
      .io_prod (w_prod)
   );

   // Widen the 8-bit partial product and move it to nibble position i+j;
   // the largest shift is 2N-8, so the term always fits in 2N bits.
   always_comb begin
      w_ext        = '0;
      w_ext[7:0]   = w_prod;
      w_shamt      = NIBBLE_W * (32'(r_i) + 32'(r_j));
      w_term       = w_ext << w_shamt;
   end

   // State register for the IDLE -> RUN -> DONE sequencer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Next-state decode; flush beats both accept and completion.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (io.io_flush)         w_nextState = IDLE;
            else if (io.io_in_valid) w_nextState = RUN;
         end
         RUN: begin
            if (io.io_flush)               w_nextState = IDLE;
            else if (w_lastI && w_lastJ)   w_nextState = DONE;
         end
         DONE: begin
            if (io.io_flush || io.io_out_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Operand capture, accumulation and nibble index walk (j inner, i outer).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lhsQ <= '0;
         r_rhsQ <= '0;
         r_acc  <= '0;
         r_i    <= '0;
         r_j    <= '0;
      end else if (io.io_flush) begin
         if (r_state != IDLE) begin
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (io.io_in_valid) begin
                  r_lhsQ <= io.io_in_lhs;
                  r_rhsQ <= io.io_in_rhs;
                  r_acc  <= '0;
                  r_i    <= '0;
                  r_j    <= '0;
               end
            end
            RUN: begin
               r_acc <= r_acc + w_term;
               if (w_lastJ) begin
                  r_j <= '0;
                  r_i <= w_lastI ? '0 : r_i + 1'b1;
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign io.io_in_ready  = (r_state == IDLE);
   assign io.io_out_valid = (r_state == DONE);
   assign io.io_busy      = (r_state == RUN) || (r_state == DONE);
   assign io.io_out_data  = r_acc;

endmodule

// File: tb/tb_nibble_serial_mult.sv
// Self-checking bench for nibble_serial_mult at N=16, N=8 and N=4.
// Expected products are pushed to per-width scoreboards when operands are
// driven and popped when the DUT presents a result.
module tb_nibble_serial_mult;
   import nibble_serial_mult_pkg::*;

   logic clk;
   logic reset;

   int errors = 0;
   int checks = 0;

   logic [31:0] sb16[$];
   logic [15:0] sb8[$];
   logic [7:0]  sb4[$];

   nibble_serial_mult_if #(.N(16)) if16 ();
   nibble_serial_mult_if #(.N(8))  if8 ();
   nibble_serial_mult_if #(.N(4))  if4 ();

   nibble_serial_mult #(.N(16)) dut16 (.clk(clk), .reset(reset), .io(if16.slave));
   nibble_serial_mult #(.N(8))  dut8  (.clk(clk), .reset(reset), .io(if8.slave));
   nibble_serial_mult #(.N(4))  dut4  (.clk(clk), .reset(reset), .io(if4.slave));

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one N=16 pair from IDLE; returns captured result and the number
   // of falling edges from the drive point until out_valid (-1 on timeout).
   task automatic drive16(input logic [15:0] lhs, input logic [15:0] rhs, input int stall,
                          output logic [31:0] data, output int lat);
      int cnt;
      if16.io_in_lhs = lhs; if16.io_in_rhs = rhs; if16.io_in_valid = 1'b1;
      if16.io_out_ready = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk); cnt++;
         if (cnt == 1) if16.io_in_valid = 1'b0;
      end while (!if16.io_out_valid && cnt < 200);
      lat  = if16.io_out_valid ? cnt : -1;
      data = if16.io_out_data;
      repeat (stall) @(negedge clk);
      if16.io_out_ready = 1'b1;
      @(negedge clk);
      if16.io_out_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (if16.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", if16.io_in_ready); end
      checks++; if (if16.io_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", if16.io_out_valid); end
      checks++; if (if16.io_out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", if16.io_out_data); end
      checks++; if (if16.io_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", if16.io_busy); end
      checks++; if (if8.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready8: got %b expected 1", if8.io_in_ready); end
      checks++; if (if4.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready4: got %b expected 1", if4.io_in_ready); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [31:0] data; logic [31:0] exp; int lat;
      sb16.push_back(32'h06260060);
      drive16(16'h1234, 16'h5678, 0, data, lat);
      exp = sb16.pop_front();
      checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 17", lat); end
      checks++; if (data !== exp) begin errors++; $display("[TB] FAIL basic_data: got %h expected %h", data, exp); end
      checks++; if (if16.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_after: got %b expected 1", if16.io_in_ready); end
      checks++; if (if16.io_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_after: got %b expected 0", if16.io_out_valid); end
   endtask

   task automatic test_extremes;
      logic [31:0] data; logic [31:0] exp; int lat;
      sb16.push_back(32'hFFFE0001);
      drive16(16'hFFFF, 16'hFFFF, 1, data, lat);
      exp = sb16.pop_front();
      checks++; if (data !== exp) begin errors++; $display("[TB] FAIL max_data: got %h expected %h", data, exp); end
      checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL max_latency: got %0d expected 17", lat); end
      sb16.push_back(32'h00000000);
      drive16(16'h0000, 16'hBEEF, 0, data, lat);
      exp = sb16.pop_front();
      checks++; if (data !== exp) begin errors++; $display("[TB] FAIL zero_data: got %h expected %h", data, exp); end
      checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 17", lat); end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp; int cnt;
      sb16.push_back(32'h0000FFFF);
      if16.io_in_lhs = 16'h00FF; if16.io_in_rhs = 16'h0101; if16.io_in_valid = 1'b1;
      if16.io_out_ready = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk); cnt++;
         if (cnt == 1) begin if16.io_in_lhs = 16'hAAAA; if16.io_in_rhs = 16'h5555; end
      end while (!if16.io_out_valid && cnt < 200);
      exp = sb16.pop_front();
      checks++; if (cnt !== 17) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 17", cnt); end
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         checks++; if (if16.io_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_hold: got %b expected 1", if16.io_out_valid); end
         checks++; if (if16.io_out_data !== exp) begin errors++; $display("[TB] FAIL bp_data_hold: got %h expected %h", if16.io_out_data, exp); end
         checks++; if (if16.io_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected 0", if16.io_in_ready); end
      end
      if16.io_in_valid = 1'b0;
      if16.io_out_ready = 1'b1;
      @(negedge clk);
      if16.io_out_ready = 1'b0;
      checks++; if (if16.io_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %b expected 0", if16.io_out_valid); end
      checks++; if (if16.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", if16.io_in_ready); end
      checks++; if (if16.io_busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_busy: got %b expected 0", if16.io_busy); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp; int cnt;
      if16.io_out_ready = 1'b1;
      if16.io_in_lhs = 16'd3; if16.io_in_rhs = 16'd5; if16.io_in_valid = 1'b1;
      sb16.push_back(32'h0000000F);
      @(negedge clk);
      if16.io_in_lhs = 16'h8000; if16.io_in_rhs = 16'd2;
      sb16.push_back(32'h00010000);
      cnt = 1;
      while (!if16.io_out_valid && cnt < 200) begin @(negedge clk); cnt++; end
      exp = sb16.pop_front();
      checks++; if (cnt !== 17) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected 17", cnt); end
      checks++; if (if16.io_out_data !== exp) begin errors++; $display("[TB] FAIL b2b_first_data: got %h expected %h", if16.io_out_data, exp); end
      @(negedge clk);
      checks++; if (if16.io_in_ready !== 1'b1 || if16.io_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got ready=%b valid=%b expected ready=1 valid=0", if16.io_in_ready, if16.io_out_valid); end
      cnt = 0;
      do begin
         @(negedge clk); cnt++;
         if (cnt == 1) if16.io_in_valid = 1'b0;
      end while (!if16.io_out_valid && cnt < 200);
      exp = sb16.pop_front();
      checks++; if (cnt !== 17) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 17", cnt); end
      checks++; if (if16.io_out_data !== exp) begin errors++; $display("[TB] FAIL b2b_second_data: got %h expected %h", if16.io_out_data, exp); end
      @(negedge clk);
      if16.io_out_ready = 1'b0;
      checks++; if (if16.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_end_ready: got %b expected 1", if16.io_in_ready); end
   endtask

   task automatic test_flush_reset;
      logic [31:0] data; logic [31:0] exp; int lat; int cnt; bit sawValid;
      // Flush partway through RUN.
      if16.io_out_ready = 1'b1;
      if16.io_in_lhs = 16'h1234; if16.io_in_rhs = 16'h5678; if16.io_in_valid = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk); cnt++;
         if (cnt == 1) if16.io_in_valid = 1'b0;
      end while (cnt < 7);
      checks++; if (if16.io_busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_busy: got %b expected 1", if16.io_busy); end
      if16.io_flush = 1'b1;
      @(negedge clk);
      if16.io_flush = 1'b0;
      checks++; if (if16.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 1", if16.io_in_ready); end
      checks++; if (if16.io_out_data !== 32'h0) begin errors++; $display("[TB] FAIL flush_acc: got %h expected 0", if16.io_out_data); end
      checks++; if (if16.io_busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", if16.io_busy); end
      sawValid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (if16.io_out_valid) sawValid = 1'b1;
      end
      checks++; if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_result: got %b expected 0", sawValid); end
      // Flush in IDLE drops a simultaneous handshake.
      if16.io_flush = 1'b1; if16.io_in_valid = 1'b1;
      @(negedge clk);
      if16.io_flush = 1'b0; if16.io_in_valid = 1'b0;
      checks++; if (if16.io_busy !== 1'b0 || if16.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle_drop: got busy=%b ready=%b expected busy=0 ready=1", if16.io_busy, if16.io_in_ready); end
      // Asynchronous reset between edges mid-RUN.
      if16.io_in_lhs = 16'h00FF; if16.io_in_rhs = 16'h0101; if16.io_in_valid = 1'b1;
      @(negedge clk);
      if16.io_in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (if16.io_out_data === 32'h0) begin errors++; $display("[TB] FAIL rst_pre_acc: got %h expected nonzero", if16.io_out_data); end
      #2 reset = 1'b1;
      #1;
      checks++; if (if16.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", if16.io_in_ready); end
      checks++; if (if16.io_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", if16.io_busy); end
      checks++; if (if16.io_out_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_data: got %h expected 0", if16.io_out_data); end
      checks++; if (if16.io_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", if16.io_out_valid); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      sb16.push_back(32'h00000100);
      drive16(16'h0010, 16'h0010, 0, data, lat);
      exp = sb16.pop_front();
      checks++; if (data !== exp) begin errors++; $display("[TB] FAIL post_rst_data: got %h expected %h", data, exp); end
      checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL post_rst_latency: got %0d expected 17", lat); end
   endtask

   task automatic test_random16;
      logic [15:0] lhs; logic [15:0] rhs; logic [31:0] data; logic [31:0] exp; int lat;
      for (int t = 0; t < 1000; t++) begin
         lhs = 16'($urandom); rhs = 16'($urandom);
         if (t % 97 == 0) lhs = 16'hFFFF;
         if (t % 89 == 0) rhs = 16'hFFFF;
         sb16.push_back(32'(lhs) * 32'(rhs));
         drive16(lhs, rhs, $urandom_range(0, 3), data, lat);
         exp = sb16.pop_front();
         checks++; if (data !== exp) begin errors++; $display("[TB] FAIL rand16_data: %h*%h got %h expected %h", lhs, rhs, data, exp); end
         checks++; if (lat !== RUN_CYCLES(16) + 1) begin errors++; $display("[TB] FAIL rand16_latency: got %0d expected %0d", lat, RUN_CYCLES(16) + 1); end
      end
   endtask

   task automatic test_random8;
      logic [7:0] lhs; logic [7:0] rhs; logic [15:0] data; logic [15:0] exp; int cnt;
      for (int t = 0; t < 300; t++) begin
         lhs = 8'($urandom); rhs = 8'($urandom);
         if (t == 0) begin lhs = 8'hFF; rhs = 8'hFF; end
         sb8.push_back(16'(lhs) * 16'(rhs));
         if8.io_in_lhs = lhs; if8.io_in_rhs = rhs; if8.io_in_valid = 1'b1; if8.io_out_ready = 1'b0;
         cnt = 0;
         do begin
            @(negedge clk); cnt++;
            if (cnt == 1) if8.io_in_valid = 1'b0;
         end while (!if8.io_out_valid && cnt < 100);
         data = if8.io_out_data;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if8.io_out_ready = 1'b1;
         @(negedge clk);
         if8.io_out_ready = 1'b0;
         exp = sb8.pop_front();
         checks++; if (data !== exp) begin errors++; $display("[TB] FAIL rand8_data: %h*%h got %h expected %h", lhs, rhs, data, exp); end
         checks++; if (cnt !== RUN_CYCLES(8) + 1) begin errors++; $display("[TB] FAIL rand8_latency: got %0d expected %0d", cnt, RUN_CYCLES(8) + 1); end
      end
   endtask

   task automatic test_random4;
      logic [3:0] lhs; logic [3:0] rhs; logic [7:0] data; logic [7:0] exp; int cnt;
      for (int t = 0; t < 300; t++) begin
         lhs = 4'($urandom); rhs = 4'($urandom);
         if (t == 0) begin lhs = 4'hF; rhs = 4'hF; end
         sb4.push_back(8'(lhs) * 8'(rhs));
         if4.io_in_lhs = lhs; if4.io_in_rhs = rhs; if4.io_in_valid = 1'b1; if4.io_out_ready = 1'b0;
         cnt = 0;
         do begin
            @(negedge clk); cnt++;
            if (cnt == 1) if4.io_in_valid = 1'b0;
         end while (!if4.io_out_valid && cnt < 100);
         data = if4.io_out_data;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if4.io_out_ready = 1'b1;
         @(negedge clk);
         if4.io_out_ready = 1'b0;
         exp = sb4.pop_front();
         checks++; if (data !== exp) begin errors++; $display("[TB] FAIL rand4_data: %h*%h got %h expected %h", lhs, rhs, data, exp); end
         checks++; if (cnt !== RUN_CYCLES(4) + 1) begin errors++; $display("[TB] FAIL rand4_latency: got %0d expected %0d", cnt, RUN_CYCLES(4) + 1); end
      end
   endtask

   // Scenario sequence.
   initial begin
      reset = 1'b1;
      if16.io_in_valid = 1'b0; if16.io_in_lhs = '0; if16.io_in_rhs = '0; if16.io_flush = 1'b0; if16.io_out_ready = 1'b0;
      if8.io_in_valid  = 1'b0; if8.io_in_lhs  = '0; if8.io_in_rhs  = '0; if8.io_flush  = 1'b0; if8.io_out_ready  = 1'b0;
      if4.io_in_valid  = 1'b0; if4.io_in_lhs  = '0; if4.io_in_rhs  = '0; if4.io_flush  = 1'b0; if4.io_out_ready  = 1'b0;
      $display("[TB] starting nibble_serial_mult bench");
      test_reset();
      test_basic();
      test_extremes();
      test_backpressure();
      test_back_to_back();
      test_flush_reset();
      test_random16();
      test_random8();
      test_random4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
